// File: rtl/lsu_if.sv
// ============================================================================
//  Module      : lsu_if
//  Description : Data-RAM request/acknowledge bus between the LSU and the RAM.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface lsu_if;
    logic        dram_req;
    logic        dram_we;
    logic [31:0] dram_addr;
    logic [31:0] dram_wdata;
    logic [3:0]  dram_be;
    logic        dram_ack;
    logic [31:0] dram_rdata;

    modport master (
        output dram_req, dram_we, dram_addr, dram_wdata, dram_be,
        input  dram_ack, dram_rdata
    );

    modport slave (
        input  dram_req, dram_we, dram_addr, dram_wdata, dram_be,
        output dram_ack, dram_rdata
    );
endinterface

`default_nettype wire

// File: rtl/lsu.sv
// ============================================================================
//  Module      : lsu
//  Description : Memory-stage load/store unit: RAM handshake, store lane
//                alignment, load extraction, misalign and timeout faults.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic        mem_valid,
    input  wire logic        mem_we,
    input  wire logic [2:0]  funct3,
    input  wire logic [31:0] addr,
    input  wire logic [31:0] st_data,
    input  wire logic        flush,
    lsu_if.master            bus,
    output logic      [31:0] dram_rd_data,
    output logic             stall,
    output logic             misalign,
    output logic             bus_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [7:0] c_TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      r_state;
    state_t      w_next;

    logic        r_we;
    logic [2:0]  r_funct3;
    logic [1:0]  r_off;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_be;
    logic [7:0]  r_cnt;
    logic [31:0] r_rd_data;
    logic        r_bus_err;

    logic        w_is_byte;
    logic        w_is_half;
    logic        w_fault;
    logic        w_accept;
    logic        w_timeout;
    logic [31:0] w_wdata;
    logic [3:0]  w_be;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load;

    // Width decode uses funct3[1:0] only, so undefined codes fall to word width.
    always_comb begin
        w_is_byte = (funct3[1:0] == 2'b00);
        w_is_half = (funct3[1:0] == 2'b01);
        w_fault   = (w_is_half & addr[0]) |
                    (!w_is_byte & !w_is_half & (addr[1:0] != 2'b00));
        w_wdata   = st_data;
        w_be      = 4'b1111;
        if (w_is_byte) begin
            w_wdata = {4{st_data[7:0]}};
            w_be    = 4'b0001 << addr[1:0];
        end else if (w_is_half) begin
            w_wdata = {2{st_data[15:0]}};
            w_be    = addr[1] ? 4'b1100 : 4'b0011;
        end
    end

    always_comb begin
        w_byte = bus.dram_rdata[{r_off, 3'b000} +: 8];
        w_half = bus.dram_rdata[{r_off[1], 4'b0000} +: 16];
        case (r_funct3)
            3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
            3'b100:  w_load = {24'd0, w_byte};
            3'b001:  w_load = {{16{w_half[15]}}, w_half};
            3'b101:  w_load = {16'd0, w_half};
            default: w_load = bus.dram_rdata;
        endcase
    end

    assign w_accept  = (r_state == S_IDLE) & mem_valid & !flush & !w_fault;
    assign w_timeout = (r_cnt == c_TIMEOUT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        stall    = 1'b0;
        misalign = 1'b0;
        case (r_state)
            S_IDLE: begin
                stall    = w_accept;
                misalign = mem_valid & !flush & w_fault;
                if (w_accept) begin
                    w_next = S_REQ;
                end
            end
            S_REQ: begin
                stall = 1'b1;
                if (bus.dram_ack || w_timeout) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_we      <= 1'b0;
            r_funct3  <= 3'd0;
            r_off     <= 2'd0;
            r_addr    <= 32'd0;
            r_wdata   <= 32'd0;
            r_be      <= 4'd0;
            r_cnt     <= 8'd0;
            r_rd_data <= 32'd0;
            r_bus_err <= 1'b0;
        end else begin
            if (w_accept) begin
                r_we     <= mem_we;
                r_funct3 <= funct3;
                r_off    <= addr[1:0];
                r_addr   <= {addr[31:2], 2'b00};
                r_wdata  <= w_wdata;
                r_be     <= mem_we ? w_be : 4'b0000;
                r_cnt    <= 8'd0;
            end
            if (r_state == S_REQ) begin
                r_cnt <= r_cnt + 8'd1;
                // Ack takes priority over a simultaneous timeout.
                if (bus.dram_ack) begin
                    if (!r_we) begin
                        r_rd_data <= w_load;
                    end
                    r_bus_err <= 1'b0;
                end else if (w_timeout) begin
                    r_rd_data <= 32'd0;
                    r_bus_err <= 1'b1;
                end
            end
        end
    end

    assign bus.dram_req   = (r_state == S_REQ);
    assign bus.dram_we    = r_we;
    assign bus.dram_addr  = r_addr;
    assign bus.dram_wdata = r_wdata;
    assign bus.dram_be    = r_be;
    assign dram_rd_data   = r_rd_data;
    assign bus_err        = r_bus_err;

endmodule

`default_nettype wire

// File: tb/tb_lsu.sv
// ============================================================================
//  Module      : tb_lsu
//  Description : Self-checking bench for lsu against a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lsu;

    localparam int T = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_valid;
    logic        mem_we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] st_data;
    logic        flush;
    logic [31:0] dram_rd_data;
    logic        stall;
    logic        misalign;
    logic        bus_err;

    lsu_if bus ();

    lsu #(.TIMEOUT_CYCLES(T)) dut (
        .clk          (clk),
        .rst          (rst),
        .mem_valid    (mem_valid),
        .mem_we       (mem_we),
        .funct3       (funct3),
        .addr         (addr),
        .st_data      (st_data),
        .flush        (flush),
        .bus          (bus),
        .dram_rd_data (dram_rd_data),
        .stall        (stall),
        .misalign     (misalign),
        .bus_err      (bus_err)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_rd;
    logic        exp_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic int ref_size(input logic [2:0] f3);
        if (f3 == 3'd0 || f3 == 3'd4) return 1;
        if (f3 == 3'd1 || f3 == 3'd5) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input int off, input logic [31:0] word);
        int          size;
        logic [31:0] v;
        size = ref_size(f3);
        if (size == 4) return word;
        v = (word >> (8 * off)) & ((size == 1) ? 32'hFF : 32'hFFFF);
        if (f3 < 3'd4) begin
            if (size == 1 && v >= 32'd128)   v = v + 32'hFFFFFF00;
            if (size == 2 && v >= 32'd32768) v = v + 32'hFFFF0000;
        end
        return v;
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] sd);
        int size;
        size = ref_size(f3);
        if (size == 1) return (sd & 32'hFF) * 32'h01010101;
        if (size == 2) return (sd & 32'hFFFF) * 32'h00010001;
        return sd;
    endfunction

    function automatic logic [3:0] ref_be(input logic [2:0] f3, input int off);
        int size;
        size = ref_size(f3);
        if (size == 1) return 4'(1 << off);
        if (size == 2) return 4'(3 << (off & 2));
        return 4'hF;
    endfunction

    // lat = REQ cycle (1-based) in which ack is raised; 0 = never.
    task automatic run_access(input logic we, input logic [2:0] f3, input logic [31:0] a,
                              input logic [31:0] sd, input logic [31:0] rd, input int lat,
                              input logic noise);
        int   size, off, req_cycles, stall_cycles, exp_req;
        logic fault, done, acked;
        size  = ref_size(f3);
        off   = int'(a[1:0]);
        fault = (off % size) != 0;
        @(negedge clk);
        mem_valid = 1'b1; mem_we = we; funct3 = f3; addr = a; st_data = sd; flush = 1'b0;
        bus.dram_ack = 1'b0;
        #1;
        if (fault) begin
            check("misalign_pulse", misalign, 1);
            check("misalign_stall", stall, 0);
            @(negedge clk);
            mem_valid = 1'b0;
            #1;
            check("misalign_noreq", bus.dram_req, 0);
            check("misalign_clear", misalign, 0);
            return;
        end
        check("accept_stall", stall, 1);
        check("accept_nofault", misalign, 0);
        stall_cycles = 1; req_cycles = 0; done = 1'b0;
        for (int c = 0; c < T + 3 && !done; c++) begin
            @(negedge clk);
            bus.dram_ack   = 1'b0;
            bus.dram_rdata = $urandom;
            if (bus.dram_req) begin
                req_cycles++;
                stall_cycles += int'(stall);
                check("req_addr", bus.dram_addr, a & 32'hFFFFFFFC);
                check("req_we", bus.dram_we, we);
                check("req_be", bus.dram_be, we ? ref_be(f3, off) : 4'h0);
                if (we) check("req_wdata", bus.dram_wdata, ref_wdata(f3, sd));
                if (noise) flush = 1'($urandom_range(0, 1));
                if (req_cycles == lat) begin
                    bus.dram_ack   = 1'b1;
                    bus.dram_rdata = rd;
                end
            end else begin
                done = 1'b1;
            end
        end
        check("done_reached", done, 1);
        acked   = (lat >= 1 && lat <= T);
        exp_req = acked ? lat : T;
        check("req_cycles", req_cycles, exp_req);
        check("stall_cycles", stall_cycles, exp_req + 1);
        check("done_stall", stall, 0);
        if (acked) begin
            if (!we) exp_rd = ref_load(f3, off, rd);
            exp_err = 1'b0;
        end else begin
            exp_rd  = 32'd0;
            exp_err = 1'b1;
        end
        check("done_rd_data", dram_rd_data, exp_rd);
        check("done_bus_err", bus_err, exp_err);
        mem_valid = 1'b0;
        flush     = 1'b0;
    endtask

    task automatic run_flush(input logic [31:0] a);
        @(negedge clk);
        mem_valid = 1'b1; mem_we = 1'($urandom_range(0, 1)); funct3 = 3'b010; addr = a; flush = 1'b1;
        #1;
        check("flush_stall", stall, 0);
        check("flush_misalign", misalign, 0);
        @(negedge clk);
        mem_valid = 1'b0; flush = 1'b0;
        #1;
        check("flush_noreq", bus.dram_req, 0);
    endtask

    task automatic stray_ack();
        @(negedge clk);
        mem_valid = 1'b0;
        bus.dram_ack = 1'b1; bus.dram_rdata = $urandom;
        @(negedge clk);
        bus.dram_ack = 1'b0;
        #1;
        check("stray_ack_rd", dram_rd_data, exp_rd);
        check("stray_ack_req", bus.dram_req, 0);
    endtask

    initial begin
        logic [2:0] f3_tab[8];
        logic [2:0] st_tab[6];
        f3_tab = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
        st_tab = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd6, 3'd7};
        rst = 1'b1; mem_valid = 1'b0; mem_we = 1'b0; funct3 = 3'd0; addr = 32'd0;
        st_data = 32'd0; flush = 1'b0; bus.dram_ack = 1'b0; bus.dram_rdata = 32'd0;
        exp_rd = 32'd0; exp_err = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_req", bus.dram_req, 0);
        check("rst_stall", stall, 0);
        check("rst_rd_data", dram_rd_data, 0);
        check("rst_bus_err", bus_err, 0);
        check("rst_addr", bus.dram_addr, 0);
        check("rst_be", bus.dram_be, 0);
        rst = 1'b0;

        run_access(1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 3, 1'b0);
        check("lw_value", dram_rd_data, 32'hDEADBEEF);
        run_access(1'b0, 3'b000, 32'h3, 32'h0, 32'h80FF7F01, 1, 1'b0);
        check("lb_value", dram_rd_data, 32'hFFFFFF80);
        run_access(1'b0, 3'b100, 32'h3, 32'h0, 32'h80FF7F01, 2, 1'b0);
        check("lbu_value", dram_rd_data, 32'h00000080);
        run_access(1'b0, 3'b001, 32'h2, 32'h0, 32'h80FF7F01, 1, 1'b0);
        check("lh_value", dram_rd_data, 32'hFFFF80FF);
        run_access(1'b0, 3'b101, 32'h0, 32'h0, 32'h80FF7F01, 1, 1'b0);
        check("lhu_value", dram_rd_data, 32'h00007F01);
        run_access(1'b1, 3'b000, 32'h2, 32'h12345678, 32'h0, 1, 1'b0);
        run_access(1'b1, 3'b001, 32'h2, 32'h12345678, 32'h0, 2, 1'b0);
        run_access(1'b0, 3'b010, 32'h6, 32'h0, 32'h0, 1, 1'b0);
        run_flush(32'h40);
        run_flush(32'h43);
        run_access(1'b0, 3'b010, 32'h20, 32'h0, 32'h11111111, 0, 1'b0);
        run_access(1'b0, 3'b010, 32'h24, 32'h0, 32'h22222222, T, 1'b0);
        stray_ack();

        // Reset in the second REQ cycle.
        @(negedge clk);
        mem_valid = 1'b1; mem_we = 1'b0; funct3 = 3'b010; addr = 32'h200;
        @(negedge clk);
        #1;
        check("rr_req1", bus.dram_req, 1);
        @(negedge clk);
        rst = 1'b1; mem_valid = 1'b0;
        #1;
        check("rr_req", bus.dram_req, 0);
        check("rr_stall", stall, 0);
        check("rr_addr", bus.dram_addr, 0);
        check("rr_rd_data", dram_rd_data, 0);
        exp_rd = 32'd0; exp_err = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        run_access(1'b0, 3'b010, 32'h300, 32'h0, 32'hCAFEF00D, 1, 1'b0);
        run_access(1'b0, 3'b010, 32'h304, 32'h0, 32'h0BADC0DE, 2, 1'b0);

        for (int i = 0; i < 150; i++) begin
            logic       we;
            logic [2:0] f3;
            we = 1'($urandom_range(0, 1));
            f3 = we ? st_tab[$urandom_range(0, 5)] : f3_tab[$urandom_range(0, 7)];
            run_access(we, f3, $urandom, $urandom, $urandom, $urandom_range(0, T + 2), 1'b1);
            if ($urandom_range(0, 9) == 0) run_flush($urandom);
            if ($urandom_range(0, 9) == 0) stray_ack();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
